// File: rtl/mcast_fanout_monitor.sv
// Passive multicast coverage monitor beside a router_cell: tracks pending multicast masks, books
// completions into a fanout histogram and exposes saturating statistics through a registered read port.
module mcast_fanout_monitor #(
  parameter int FLIT_W         = 64,
  parameter int NUM_PORTS      = 5,
  parameter int MCAST_FLAG_BIT = 31,
  parameter int MCAST_MASK_LSB = 26,
  parameter int PEND_DEPTH     = 4,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT        = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [FLIT_W-1:0]             inj_flit,
  input  logic                          inj_valid,
  input  logic                          inj_ready,
  input  logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  input  logic                          clr_stats,
  input  logic [4:0]                    rd_sel,
  output logic [CNT_W-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [$clog2(PEND_DEPTH):0]   pend_count,
  output logic                          busy
);

  localparam int PTR_W       = $clog2(PEND_DEPTH);
  localparam int AGE_W       = $clog2(TIMEOUT);
  localparam int NUM_CNT     = 6 + NUM_PORTS;
  localparam int IDX_PACKETS = 0;
  localparam int IDX_GE2     = 1;
  localparam int IDX_TIMEOUT = 2;
  localparam int IDX_OVF     = 3;
  localparam int IDX_UNICAST = 4;
  localparam int IDX_ZMASK   = 5;
  localparam int IDX_HIST    = 6;

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(PEND_DEPTH);
  localparam logic [AGE_W-1:0] AGE_LAST  = AGE_W'(TIMEOUT - 1);

  logic [NUM_PORTS-1:0] q_mask [PEND_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W:0]       count;
  logic [NUM_PORTS-1:0] seen;
  logic [AGE_W-1:0]     age;
  logic [CNT_W-1:0]     cnt [NUM_CNT];

  logic                 head_valid;
  logic                 inj;
  logic                 inj_flag;
  logic                 push_req;
  logic                 push;
  logic                 overflow;
  logic                 complete;
  logic                 timeout;
  logic                 pop;
  logic [NUM_PORTS-1:0] inj_mask;
  logic [NUM_PORTS-1:0] hs;
  logic [NUM_PORTS-1:0] head_mask;
  logic [NUM_PORTS-1:0] seen_next;
  logic [NUM_CNT-1:0]   cnt_inc;
  logic [CNT_W-1:0]     rd_mux;
  int                   fanout;

  // Only the flag bit and mask field of the flit matter to the monitor.
  logic unused_flit_bits;
  assign unused_flit_bits = ^inj_flit;

  always_comb begin
    hs         = out_valid & out_ready;
    head_valid = (count != '0);
    head_mask  = q_mask[rd_ptr];
    seen_next  = seen | (hs & head_mask);
    complete   = head_valid && enable && ((seen_next & head_mask) == head_mask);
    timeout    = head_valid && enable && !complete && (age == AGE_LAST);
    pop        = complete || timeout;
    inj        = enable && inj_valid && inj_ready;
    inj_flag   = inj_flit[MCAST_FLAG_BIT];
    inj_mask   = inj_flit[MCAST_MASK_LSB +: NUM_PORTS];
    push_req   = inj && inj_flag && (inj_mask != '0);
    // A pop in the same cycle frees the slot, so a full queue only overflows without one.
    overflow   = push_req && (count == DEPTH_CNT) && !pop;
    push       = push_req && !overflow;
    fanout     = $countones(head_mask);
  end

  always_comb begin
    cnt_inc              = '0;
    cnt_inc[IDX_PACKETS] = complete;
    cnt_inc[IDX_GE2]     = complete && (fanout >= 2);
    cnt_inc[IDX_TIMEOUT] = timeout;
    cnt_inc[IDX_OVF]     = overflow;
    cnt_inc[IDX_UNICAST] = inj && !inj_flag;
    cnt_inc[IDX_ZMASK]   = inj && inj_flag && (inj_mask == '0);
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (complete && (fanout == k)) cnt_inc[IDX_HIST + k - 1] = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(rd_sel) == i) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      seen   <= '0;
      age    <= '0;
      for (int i = 0; i < PEND_DEPTH; i++) q_mask[i] <= '0;
    end else begin
      if (push) begin
        q_mask[wr_ptr] <= inj_mask;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // New head starts with nothing delivered and a fresh age.
      if (pop) begin
        seen <= '0;
        age  <= '0;
      end else if (head_valid && enable) begin
        seen <= seen_next;
        age  <= age + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      rd_data  <= rd_mux;
      rd_valid <= 1'b1;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clr_stats)                          cnt[i] <= '0;
        else if (cnt_inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign pend_count = count;
  assign busy       = head_valid;

endmodule

// File: tb/tb_mcast_fanout_monitor.sv
// Bench for mcast_fanout_monitor: directed scenarios plus randomized traffic against a queue-based model.
module tb_mcast_fanout_monitor;

  localparam int FLIT_W  = 64;
  localparam int NP      = 5;
  localparam int FLAG    = 31;
  localparam int LSB     = 26;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int NCNT    = 6 + NP;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [FLIT_W-1:0] inj_flit;
  logic              inj_valid;
  logic              inj_ready;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_ready;
  logic              clr_stats;
  logic [4:0]        rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [2:0]        pend_count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  mcast_fanout_monitor #(
    .FLIT_W(FLIT_W), .NUM_PORTS(NP), .MCAST_FLAG_BIT(FLAG), .MCAST_MASK_LSB(LSB),
    .PEND_DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .inj_flit(inj_flit), .inj_valid(inj_valid),
    .inj_ready(inj_ready), .out_valid(out_valid), .out_ready(out_ready), .clr_stats(clr_stats),
    .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .pend_count(pend_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of outstanding masks, delivered set of the head, head age, plain counters.
  logic [NP-1:0]    mq[$];
  logic [NP-1:0]    m_seen;
  int               m_age;
  int               m_cnt[NCNT];
  logic [CNT_W-1:0] m_rd;
  logic             m_rdv;

  function automatic void model_reset();
    mq.delete();
    m_seen = '0;
    m_age  = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_rd   = '0;
    m_rdv  = 1'b0;
  endfunction

  function automatic void bump(int i);
    if (m_cnt[i] < CMAX) m_cnt[i]++;
  endfunction

  function automatic void model_step();
    logic [NP-1:0] hs, m, sa, imask;
    int pc;
    hs    = out_valid & out_ready;
    m_rd  = (int'(rd_sel) < NCNT) ? CNT_W'(m_cnt[int'(rd_sel)]) : '0;
    m_rdv = 1'b1;
    if (enable && mq.size() > 0) begin
      m  = mq[0];
      sa = m_seen | (hs & m);
      if (sa == m) begin
        void'(mq.pop_front());
        pc = $countones(m);
        bump(0);
        bump(6 + pc - 1);
        if (pc >= 2) bump(1);
        m_seen = '0;
        m_age  = 0;
      end else if (m_age == TIMEOUT - 1) begin
        void'(mq.pop_front());
        bump(2);
        m_seen = '0;
        m_age  = 0;
      end else begin
        m_seen = sa;
        m_age++;
      end
    end
    if (enable && inj_valid && inj_ready) begin
      imask = inj_flit[LSB +: NP];
      if (!inj_flit[FLAG])         bump(4);
      else if (imask == '0)        bump(5);
      else if (mq.size() < DEPTH)  mq.push_back(imask);
      else                         bump(3);
    end
    if (clr_stats) foreach (m_cnt[i]) m_cnt[i] = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(logic flag, logic [NP-1:0] mask);
    logic [FLIT_W-1:0] f;
    f = {$urandom, $urandom};
    f[FLAG] = flag;
    f[LSB +: NP] = mask;
    return f;
  endfunction

  task automatic idle();
    enable    = 1'b1;
    inj_valid = 1'b0;
    inj_ready = 1'b1;
    out_valid = '0;
    out_ready = '0;
    clr_stats = 1'b0;
    rd_sel    = '0;
  endtask

  task automatic inject(logic flag, logic [NP-1:0] mask);
    inj_flit  = mk_flit(flag, mask);
    inj_valid = 1'b1;
    inj_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL rst_pend: got %0d expected 0", pend_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rdv: got %0b expected 0", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rdata: got %0d expected 0", rd_data); end
    #8;
    rst = 1'b0;
    step();
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rst_rdv_after: got %0b expected 1", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rdata_after: got %0d expected 0", rd_data); end
  endtask

  task automatic test_fanout_same_cycle();
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    inject(1'b1, 5'b01010); step(); inj_valid = 1'b0;
    step(); step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_wait: got %0b expected 1", busy); end
    out_valid = 5'b01010; out_ready = 5'b11111; step(); out_valid = '0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_done: got %0b expected 0", busy); end
    rd_sel = 5'd0; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t1_packets: got %0d expected 1", rd_data); end
    rd_sel = 5'd7; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t1_hist2: got %0d expected 1", rd_data); end
    rd_sel = 5'd1; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t1_ge2: got %0d expected 1", rd_data); end
  endtask

  task automatic test_spread_delivery();
    logic [NP-1:0] hs_seq [5] = '{5'b00100, 5'b00001, 5'b01000, 5'b00001, 5'b10000};
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    inject(1'b1, 5'b11100); step(); inj_valid = 1'b0;
    out_ready = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      out_valid = hs_seq[i]; step();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t2_busy_%0d: got %0b expected 1", i, busy); end
    end
    out_valid = hs_seq[4]; step(); out_valid = '0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy_done: got %0b expected 0", busy); end
    rd_sel = 5'd0; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t2_packets: got %0d expected 1", rd_data); end
    rd_sel = 5'd8; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t2_hist3: got %0d expected 1", rd_data); end
    rd_sel = 5'd6; step();
    n_checks++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL t2_hist1: got %0d expected 0", rd_data); end
  endtask

  task automatic test_timeout();
    int cyc;
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    inject(1'b1, 5'b00001); step(); inj_valid = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin step(); cyc++; end
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL t3_pop_cycles: got %0d expected 8", cyc); end
    rd_sel = 5'd2; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t3_timeouts: got %0d expected 1", rd_data); end
    rd_sel = 5'd0; step();
    n_checks++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL t3_packets: got %0d expected 0", rd_data); end
  endtask

  task automatic test_overflow();
    logic [NP-1:0] masks [5] = '{5'b00011, 5'b00100, 5'b11000, 5'b00001, 5'b10101};
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) begin inject(1'b1, masks[i]); step(); end
    inj_valid = 1'b0;
    n_checks++; if (pend_count !== 3'd4) begin n_fail++; $display("FAIL t4_pend_full: got %0d expected 4", pend_count); end
    inject(1'b1, 5'b01000); out_valid = 5'b00011; out_ready = 5'b11111; rd_sel = 5'd3; step();
    inj_valid = 1'b0; out_valid = '0;
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t4_ovf_pre: got %0d expected 1", rd_data); end
    n_checks++; if (pend_count !== 3'd4) begin n_fail++; $display("FAIL t4_pend_swap: got %0d expected 4", pend_count); end
    step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL t4_ovf_post: got %0d expected 1", rd_data); end
    out_valid = 5'b11111;
    for (int i = 0; i < 4; i++) step();
    out_valid = '0;
    n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL t4_drain: got %0d expected 0", pend_count); end
    rd_sel = 5'd0; step();
    n_checks++; if (rd_data !== 4'd5) begin n_fail++; $display("FAIL t4_packets: got %0d expected 5", rd_data); end
    rd_sel = 5'd6; step();
    n_checks++; if (rd_data !== 4'd3) begin n_fail++; $display("FAIL t4_hist1: got %0d expected 3", rd_data); end
  endtask

  task automatic test_mix();
    logic          flags [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [NP-1:0] masks [6] = '{5'b11111, 5'b00011, 5'b00000, 5'b00101, 5'b10000, 5'b00000};
    logic [4:0]    sels  [6] = '{5'd4, 5'd5, 5'd0, 5'd6, 5'd7, 5'd31};
    logic [3:0]    exps  [6] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    out_valid = 5'b11111; out_ready = 5'b11111;
    for (int i = 0; i < 6; i++) begin inject(flags[i], masks[i]); step(); end
    inj_valid = 1'b0; step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy: got %0b expected 0", busy); end
    out_valid = '0;
    for (int i = 0; i < 6; i++) begin
      rd_sel = sels[i]; step();
      n_checks++; if (rd_data !== exps[i]) begin n_fail++; $display("FAIL t5_sel%0d: got %0d expected %0d", sels[i], rd_data, exps[i]); end
    end
  endtask

  task automatic test_enable();
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    inject(1'b1, 5'b00110); step();
    enable = 1'b0; out_valid = 5'b11111; out_ready = 5'b11111;
    for (int i = 0; i < 12; i++) begin inject(i[0], 5'b00001); step(); end
    inj_valid = 1'b0;
    n_checks++; if (pend_count !== 3'd1) begin n_fail++; $display("FAIL en_frozen: got %0d expected 1", pend_count); end
    rd_sel = 5'd4; step();
    n_checks++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL en_unicast: got %0d expected 0", rd_data); end
    enable = 1'b1; step();
    n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL en_resume: got %0d expected 0", pend_count); end
    rd_sel = 5'd0; out_valid = '0; step();
    n_checks++; if (rd_data !== 4'd1) begin n_fail++; $display("FAIL en_packets: got %0d expected 1", rd_data); end
  endtask

  task automatic test_saturation_and_reset();
    idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
    out_valid = 5'b11111; out_ready = 5'b11111;
    for (int i = 0; i < 20; i++) begin inject(1'b1, 5'b00001); step(); end
    inj_valid = 1'b0; step();
    out_valid = '0; rd_sel = 5'd0; step();
    n_checks++; if (rd_data !== 4'd15) begin n_fail++; $display("FAIL t6_sat: got %0d expected 15", rd_data); end
    inject(1'b1, 5'b00010); step(); inj_valid = 1'b0;
    out_valid = 5'b00010; clr_stats = 1'b1; step(); clr_stats = 1'b0; out_valid = '0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_clr_pop: got %0b expected 0", busy); end
    step();
    n_checks++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL t6_clr_wins: got %0d expected 0", rd_data); end
    inject(1'b1, 5'b00100); step(); inject(1'b1, 5'b01000); step(); inj_valid = 1'b0;
    n_checks++; if (pend_count !== 3'd2) begin n_fail++; $display("FAIL t6_pend2: got %0d expected 2", pend_count); end
    #2; rst = 1'b1; #1;
    n_checks++; if (pend_count !== 3'd0) begin n_fail++; $display("FAIL t6_async_pend: got %0d expected 0", pend_count); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async_rdv: got %0b expected 0", rd_valid); end
    model_reset();
    step();
    rst = 1'b0; step();
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 4'd0) begin n_fail++; $display("FAIL t6_post_rst: got rdv=%0b data=%0d expected rdv=1 data=0", rd_valid, rd_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      inj_valid = $urandom_range(0, 1);
      inj_ready = ($urandom_range(0, 4) != 0);
      inj_flit  = mk_flit(($urandom_range(0, 9) < 7), NP'($urandom_range(0, 31)));
      out_valid = NP'($urandom & $urandom & $urandom);
      out_ready = NP'($urandom | $urandom);
      clr_stats = ($urandom_range(0, 49) == 0);
      rd_sel    = 5'($urandom_range(0, 31));
      step();
      n_checks++; if (pend_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_pend c=%0d: got %0d expected %0d", c, pend_count, mq.size()); end
      n_checks++; if (busy !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %0b expected %0b", c, busy, mq.size() != 0); end
      n_checks++; if (rd_data !== m_rd) begin n_fail++; $display("FAIL rnd_rdata c=%0d sel=%0d: got %0d expected %0d", c, rd_sel, rd_data, m_rd); end
      n_checks++; if (rd_valid !== m_rdv) begin n_fail++; $display("FAIL rnd_rdv c=%0d: got %0b expected %0b", c, rd_valid, m_rdv); end
    end
  endtask

  initial begin
    rst = 1'b1;
    inj_flit = '0;
    idle();
    model_reset();
    test_reset();
    test_fanout_same_cycle();
    test_spread_delivery();
    test_timeout();
    test_overflow();
    test_mix();
    test_enable();
    test_saturation_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
